res_st_ctrl: RTL and testbench

Reservation-station controller for the Qu out-of-order core. It holds `RES_ST_DEPTH` entries of type `res_st_cell_t`. Each entry moves through a per-slot state machine: it is allocated at dispatch, snoops the common data bus (CDB) to resolve pending operands, and is issued to a functional unit through a registered valid/ready port. The slot is released only when its own result tag is broadcast, so tags never alias while a result is in flight.

---
 rtl/res_st_ctrl.sv | 264 ++++++++++++++++++++++++++
 tb/tb_res_st_ctrl.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/res_st_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : res_st_ctrl
// Brief    : Reservation-station controller. Slots 1..DEPTH-1 are allocated
//            at dispatch, snoop the CDB for pending operands, issue through a
//            registered valid/ready port and are released when their own
//            result tag is broadcast.
// Revision : 1.0 - initial release
// ============================================================================
module res_st_ctrl #(
  parameter int DEPTH = 32,  // RES_ST_DEPTH
  parameter int TAG_W = 5,   // RES_ST_ADDR_WIDTH
  parameter int OP_W  = 13,  // RES_ST_OP_WIDTH
  parameter int VW    = 32,  // RES_ST_VDATA_WIDTH
  parameter int AW    = 12   // RES_ST_ADATA_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush_i,
  // dispatch
  input  logic             disp_valid_i,
  output logic             disp_ready_o,
  input  logic [OP_W-1:0]  disp_op_i,
  input  logic [TAG_W-1:0] disp_qj_i,
  input  logic [TAG_W-1:0] disp_qk_i,
  input  logic [VW-1:0]    disp_vj_i,
  input  logic [VW-1:0]    disp_vk_i,
  input  logic [AW-1:0]    disp_a_i,
  output logic [TAG_W-1:0] disp_tag_o,
  // common data bus
  input  logic             cdb_valid_i,
  input  logic [TAG_W-1:0] cdb_tag_i,
  input  logic [VW-1:0]    cdb_data_i,
  // issue
  output logic             iss_valid_o,
  input  logic             iss_ready_i,
  output logic [TAG_W-1:0] iss_tag_o,
  output logic [OP_W-1:0]  iss_op_o,
  output logic [VW-1:0]    iss_vj_o,
  output logic [VW-1:0]    iss_vk_o,
  output logic [AW-1:0]    iss_a_o,
  // occupancy
  output logic [TAG_W:0]   free_count_o
);

  typedef enum logic [1:0] {
    ST_FREE   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_READY  = 2'd2,
    ST_ISSUED = 2'd3
  } slot_state_e;

  // Slot 0 is reserved (tag 0 means "operand available"), so it has no storage.
  slot_state_e      state_q [1:DEPTH-1];
  slot_state_e      state_d [1:DEPTH-1];
  logic [OP_W-1:0]  op_q    [1:DEPTH-1];
  logic [OP_W-1:0]  op_d    [1:DEPTH-1];
  logic [TAG_W-1:0] qj_q    [1:DEPTH-1];
  logic [TAG_W-1:0] qj_d    [1:DEPTH-1];
  logic [TAG_W-1:0] qk_q    [1:DEPTH-1];
  logic [TAG_W-1:0] qk_d    [1:DEPTH-1];
  logic [VW-1:0]    vj_q    [1:DEPTH-1];
  logic [VW-1:0]    vj_d    [1:DEPTH-1];
  logic [VW-1:0]    vk_q    [1:DEPTH-1];
  logic [VW-1:0]    vk_d    [1:DEPTH-1];
  logic [AW-1:0]    a_q     [1:DEPTH-1];
  logic [AW-1:0]    a_d     [1:DEPTH-1];

  logic             iss_valid_q, iss_valid_d;
  logic [TAG_W-1:0] iss_tag_q,   iss_tag_d;
  logic [OP_W-1:0]  iss_op_q,    iss_op_d;
  logic [VW-1:0]    iss_vj_q,    iss_vj_d;
  logic [VW-1:0]    iss_vk_q,    iss_vk_d;
  logic [AW-1:0]    iss_a_q,     iss_a_d;
  logic [TAG_W:0]   free_count_q, free_count_d;

  logic             alloc_any;
  logic [TAG_W-1:0] alloc_tag;
  logic             sel_any;
  logic [TAG_W-1:0] sel_idx;
  logic             cdb_hit;
  logic             disp_fire;
  logic             iss_open;

  assign cdb_hit   = cdb_valid_i && (cdb_tag_i != '0);
  assign disp_fire = disp_valid_i && alloc_any;
  assign iss_open  = !iss_valid_q || iss_ready_i;

  // Priority encoders: lowest FREE slot for allocation, lowest READY slot for issue.
  always_comb begin
    alloc_any = 1'b0;
    alloc_tag = '0;
    sel_any   = 1'b0;
    sel_idx   = '0;
    for (int i = DEPTH - 1; i >= 1; i--) begin
      if (state_q[i] == ST_FREE) begin
        alloc_any = 1'b1;
        alloc_tag = TAG_W'(i);
      end
      if (state_q[i] == ST_READY) begin
        sel_any = 1'b1;
        sel_idx = TAG_W'(i);
      end
    end
  end

  // Per-slot next state: allocation with CDB bypass, wakeup, issue and release.
  always_comb begin
    for (int i = 1; i < DEPTH; i++) begin
      state_d[i] = state_q[i];
      op_d[i]    = op_q[i];
      qj_d[i]    = qj_q[i];
      qk_d[i]    = qk_q[i];
      vj_d[i]    = vj_q[i];
      vk_d[i]    = vk_q[i];
      a_d[i]     = a_q[i];
      if (flush_i) begin
        state_d[i] = ST_FREE;
        op_d[i]    = '0;
        qj_d[i]    = '0;
        qk_d[i]    = '0;
        vj_d[i]    = '0;
        vk_d[i]    = '0;
        a_d[i]     = '0;
      end else begin
        unique case (state_q[i])
          ST_FREE: begin
            if (disp_fire && (alloc_tag == TAG_W'(i))) begin
              op_d[i] = disp_op_i;
              a_d[i]  = disp_a_i;
              qj_d[i] = disp_qj_i;
              vj_d[i] = disp_vj_i;
              qk_d[i] = disp_qk_i;
              vk_d[i] = disp_vk_i;
              // An operand produced in the dispatch cycle would otherwise be missed.
              if (cdb_hit && (disp_qj_i == cdb_tag_i)) begin
                qj_d[i] = '0;
                vj_d[i] = cdb_data_i;
              end
              if (cdb_hit && (disp_qk_i == cdb_tag_i)) begin
                qk_d[i] = '0;
                vk_d[i] = cdb_data_i;
              end
              state_d[i] = ((qj_d[i] == '0) && (qk_d[i] == '0)) ? ST_READY : ST_WAIT;
            end
          end
          ST_WAIT: begin
            if (cdb_hit && (qj_q[i] == cdb_tag_i)) begin
              qj_d[i] = '0;
              vj_d[i] = cdb_data_i;
            end
            if (cdb_hit && (qk_q[i] == cdb_tag_i)) begin
              qk_d[i] = '0;
              vk_d[i] = cdb_data_i;
            end
            if ((qj_d[i] == '0) && (qk_d[i] == '0)) begin
              state_d[i] = ST_READY;
            end
          end
          ST_READY: begin
            if (iss_open && sel_any && (sel_idx == TAG_W'(i))) begin
              state_d[i] = ST_ISSUED;
            end
          end
          ST_ISSUED: begin
            // Hold the tag until its own result is broadcast so tags never alias.
            if (cdb_hit && (cdb_tag_i == TAG_W'(i))) begin
              state_d[i] = ST_FREE;
            end
          end
          default: state_d[i] = ST_FREE;
        endcase
      end
    end
  end

  // Issue register: loads the selected slot when open, holds under backpressure.
  always_comb begin
    iss_valid_d = iss_valid_q;
    iss_tag_d   = iss_tag_q;
    iss_op_d    = iss_op_q;
    iss_vj_d    = iss_vj_q;
    iss_vk_d    = iss_vk_q;
    iss_a_d     = iss_a_q;
    if (flush_i) begin
      iss_valid_d = 1'b0;
      iss_tag_d   = '0;
      iss_op_d    = '0;
      iss_vj_d    = '0;
      iss_vk_d    = '0;
      iss_a_d     = '0;
    end else if (iss_open) begin
      iss_valid_d = sel_any;
      if (sel_any) begin
        iss_tag_d = sel_idx;
        iss_op_d  = op_q[sel_idx];
        iss_vj_d  = vj_q[sel_idx];
        iss_vk_d  = vk_q[sel_idx];
        iss_a_d   = a_q[sel_idx];
      end
    end
  end

  // Occupancy counts the post-edge slot states so the register tracks the slots.
  always_comb begin
    free_count_d = '0;
    for (int i = 1; i < DEPTH; i++) begin
      if (state_d[i] == ST_FREE) begin
        free_count_d = free_count_d + {{TAG_W{1'b0}}, 1'b1};
      end
    end
  end

  // State register for all slots, the issue register and the free counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 1; i < DEPTH; i++) begin
        state_q[i] <= ST_FREE;
        op_q[i]    <= '0;
        qj_q[i]    <= '0;
        qk_q[i]    <= '0;
        vj_q[i]    <= '0;
        vk_q[i]    <= '0;
        a_q[i]     <= '0;
      end
      iss_valid_q  <= 1'b0;
      iss_tag_q    <= '0;
      iss_op_q     <= '0;
      iss_vj_q     <= '0;
      iss_vk_q     <= '0;
      iss_a_q      <= '0;
      free_count_q <= (TAG_W+1)'(DEPTH - 1);
    end else begin
      for (int i = 1; i < DEPTH; i++) begin
        state_q[i] <= state_d[i];
        op_q[i]    <= op_d[i];
        qj_q[i]    <= qj_d[i];
        qk_q[i]    <= qk_d[i];
        vj_q[i]    <= vj_d[i];
        vk_q[i]    <= vk_d[i];
        a_q[i]     <= a_d[i];
      end
      iss_valid_q  <= iss_valid_d;
      iss_tag_q    <= iss_tag_d;
      iss_op_q     <= iss_op_d;
      iss_vj_q     <= iss_vj_d;
      iss_vk_q     <= iss_vk_d;
      iss_a_q      <= iss_a_d;
      free_count_q <= free_count_d;
    end
  end

  assign disp_ready_o = alloc_any;
  assign disp_tag_o   = alloc_tag;
  assign iss_valid_o  = iss_valid_q;
  assign iss_tag_o    = iss_tag_q;
  assign iss_op_o     = iss_op_q;
  assign iss_vj_o     = iss_vj_q;
  assign iss_vk_o     = iss_vk_q;
  assign iss_a_o      = iss_a_q;
  assign free_count_o = free_count_q;

endmodule
`default_nettype wire

// File: tb/tb_res_st_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_res_st_ctrl
// Brief    : Self-checking bench for res_st_ctrl. Expected issue records are
//            queued at dispatch and compared on each accepted issue.
// Revision : 1.0 - initial release
// ============================================================================
module tb_res_st_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush_i;
  logic        disp_valid_i;
  logic        disp_ready_o;
  logic [12:0] disp_op_i;
  logic [4:0]  disp_qj_i, disp_qk_i;
  logic [31:0] disp_vj_i, disp_vk_i;
  logic [11:0] disp_a_i;
  logic [4:0]  disp_tag_o;
  logic        cdb_valid_i;
  logic [4:0]  cdb_tag_i;
  logic [31:0] cdb_data_i;
  logic        iss_valid_o;
  logic        iss_ready_i;
  logic [4:0]  iss_tag_o;
  logic [12:0] iss_op_o;
  logic [31:0] iss_vj_o, iss_vk_o;
  logic [11:0] iss_a_o;
  logic [5:0]  free_count_o;

  typedef struct packed {
    logic [4:0]  tag;
    logic [12:0] op;
    logic [31:0] vj;
    logic [31:0] vk;
    logic [11:0] a;
  } iss_rec_t;

  iss_rec_t sb_q[$];
  int n_checks = 0;
  int n_pass   = 0;

  res_st_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .flush_i      (flush_i),
    .disp_valid_i (disp_valid_i),
    .disp_ready_o (disp_ready_o),
    .disp_op_i    (disp_op_i),
    .disp_qj_i    (disp_qj_i),
    .disp_qk_i    (disp_qk_i),
    .disp_vj_i    (disp_vj_i),
    .disp_vk_i    (disp_vk_i),
    .disp_a_i     (disp_a_i),
    .disp_tag_o   (disp_tag_o),
    .cdb_valid_i  (cdb_valid_i),
    .cdb_tag_i    (cdb_tag_i),
    .cdb_data_i   (cdb_data_i),
    .iss_valid_o  (iss_valid_o),
    .iss_ready_i  (iss_ready_i),
    .iss_tag_o    (iss_tag_o),
    .iss_op_o     (iss_op_o),
    .iss_vj_o     (iss_vj_o),
    .iss_vk_o     (iss_vk_o),
    .iss_a_o      (iss_a_o),
    .free_count_o (free_count_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_disp(input logic [12:0] op, input logic [4:0] qj, input logic [4:0] qk,
                          input logic [31:0] vj, input logic [31:0] vk, input logic [11:0] a);
    disp_valid_i = 1'b1;
    disp_op_i    = op;
    disp_qj_i    = qj;
    disp_qk_i    = qk;
    disp_vj_i    = vj;
    disp_vk_i    = vk;
    disp_a_i     = a;
  endtask

  task automatic cdb_pulse(input logic [4:0] tag, input logic [31:0] data);
    cdb_valid_i = 1'b1;
    cdb_tag_i   = tag;
    cdb_data_i  = data;
    tick();
    cdb_valid_i = 1'b0;
  endtask

  // Scoreboard: every accepted issue must match the oldest expected record.
  always @(negedge clk) begin
    if (!rst && iss_valid_o && iss_ready_i) begin
      if (sb_q.size() == 0) begin
        check("unexpected_issue", {123'd0, iss_tag_o}, 128'd0);
      end else begin
        iss_rec_t e;
        e = sb_q.pop_front();
        check("issue_payload", {34'd0, iss_tag_o, iss_op_o, iss_vj_o, iss_vk_o, iss_a_o}, {34'd0, e});
      end
    end
  end

  initial begin
    rst = 1'b1; flush_i = 1'b0; disp_valid_i = 1'b0; iss_ready_i = 1'b0;
    disp_op_i = '0; disp_qj_i = '0; disp_qk_i = '0; disp_vj_i = '0; disp_vk_i = '0; disp_a_i = '0;
    cdb_valid_i = 1'b0; cdb_tag_i = '0; cdb_data_i = '0;

    // Reset
    tick(); tick();
    rst = 1'b0;
    check("rst_free_count", free_count_o, 31);
    check("rst_disp_ready", disp_ready_o, 1);
    check("rst_disp_tag",   disp_tag_o,   1);
    check("rst_iss_valid",  iss_valid_o,  0);
    check("rst_iss_tag",    iss_tag_o,    0);

    // Ready-at-dispatch with backpressure
    set_disp(13'h001, 5'd0, 5'd0, 32'd5, 32'd7, 12'h0A0);
    check("disp_tag_first", disp_tag_o, 1);
    sb_q.push_back('{tag: 5'd1, op: 13'h001, vj: 32'd5, vk: 32'd7, a: 12'h0A0});
    tick();
    disp_valid_i = 1'b0;
    check("lat_cycle1_valid", iss_valid_o, 0);
    check("free_after_disp", free_count_o, 30);
    tick();
    check("lat_cycle2_valid", iss_valid_o, 1);
    check("lat_cycle2_tag",   iss_tag_o,   1);
    for (int k = 0; k < 3; k++) begin
      tick();
      check("bp_valid_hold", iss_valid_o, 1);
      check("bp_payload_hold", {iss_tag_o, iss_vj_o, iss_vk_o, iss_a_o}, {5'd1, 32'd5, 32'd7, 12'h0A0});
    end
    iss_ready_i = 1'b1;
    tick();
    check("accept_valid_drop", iss_valid_o, 0);
    tick();
    check("free_before_release", free_count_o, 30);
    cdb_pulse(5'd1, 32'd0);
    check("free_after_release", free_count_o, 31);

    // Wakeup through the CDB
    set_disp(13'h002, 5'd3, 5'd0, 32'd0, 32'd9, 12'h001);
    sb_q.push_back('{tag: 5'd1, op: 13'h002, vj: 32'hDEADBEEF, vk: 32'd9, a: 12'h001});
    tick();
    disp_valid_i = 1'b0;
    tick(); tick();
    check("wait_no_issue", iss_valid_o, 0);
    cdb_pulse(5'd3, 32'hDEADBEEF);
    check("wake_t1_valid", iss_valid_o, 0);
    tick();
    check("wake_t2_valid", iss_valid_o, 1);
    check("wake_t2_vj", iss_vj_o, 32'hDEADBEEF);
    tick();
    cdb_pulse(5'd1, 32'd0);
    check("free_after_wake_release", free_count_o, 31);

    // Dispatch-cycle bypass
    set_disp(13'h003, 5'd4, 5'd0, 32'd0, 32'd1, 12'h002);
    cdb_valid_i = 1'b1; cdb_tag_i = 5'd4; cdb_data_i = 32'h12345678;
    sb_q.push_back('{tag: 5'd1, op: 13'h003, vj: 32'h12345678, vk: 32'd1, a: 12'h002});
    tick();
    disp_valid_i = 1'b0; cdb_valid_i = 1'b0;
    check("byp_t1_valid", iss_valid_o, 0);
    tick();
    check("byp_t2_valid", iss_valid_o, 1);
    tick();
    cdb_pulse(5'd1, 32'd0);

    // Fill all slots, issue in tag order, then release
    for (int k = 1; k <= 31; k++) begin
      set_disp(13'(k + 16), 5'd0, 5'd0, 32'(k * 3), 32'(k + 100), 12'(k));
      check("fill_disp_tag", disp_tag_o, k);
      sb_q.push_back('{tag: 5'(k), op: 13'(k + 16), vj: 32'(k * 3), vk: 32'(k + 100), a: 12'(k)});
      tick();
    end
    disp_valid_i = 1'b0;
    check("full_disp_ready", disp_ready_o, 0);
    check("full_free_count", free_count_o, 0);
    check("full_disp_tag", disp_tag_o, 0);
    set_disp(13'h1FF, 5'd0, 5'd0, 32'd1, 32'd1, 12'd1);
    tick();
    disp_valid_i = 1'b0;
    tick(); tick();
    check("full_sb_drained", sb_q.size(), 0);
    cdb_pulse(5'd1, 32'd0);
    check("rel1_disp_ready", disp_ready_o, 1);
    check("rel1_disp_tag",   disp_tag_o,   1);
    check("rel1_free_count", free_count_o, 1);
    for (int k = 2; k <= 31; k++) cdb_pulse(5'(k), 32'd0);
    check("rel_all_free", free_count_o, 31);

    // Flush with waiting slots and a held issue
    iss_ready_i = 1'b0;
    set_disp(13'h0AA, 5'd0, 5'd0, 32'd11, 32'd22, 12'h033);
    tick();
    for (int k = 0; k < 5; k++) begin
      set_disp(13'(k + 64), 5'd20, 5'd0, 32'd0, 32'd1, 12'd0);
      tick();
    end
    check("pre_flush_valid", iss_valid_o, 1);
    check("pre_flush_free", free_count_o, 25);
    set_disp(13'h0BB, 5'd0, 5'd0, 32'd1, 32'd2, 12'd3);
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    disp_valid_i = 1'b0;
    check("flush_iss_valid", iss_valid_o, 0);
    check("flush_free_count", free_count_o, 31);
    check("flush_disp_tag", disp_tag_o, 1);
    iss_ready_i = 1'b1;
    cdb_pulse(5'd20, 32'd5);
    tick(); tick();
    check("flush_no_issue", iss_valid_o, 0);
    check("flush_stale_cdb_free", free_count_o, 31);
    check("final_sb_empty", sb_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
